// File: rtl/riscv_csrbus_initiator_pkg.sv
// riscv_csrbus_initiator_pkg: shared encodings for the CSR bus initiator
// Provides the Zicsr funct3 encodings, FSM states, privilege levels and the read-only field code.
package riscv_csrbus_initiator_pkg;
    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] RO_FIELD = 2'b11;
endpackage

// File: rtl/riscv_csrbus_if.sv
// riscv_csrbus_if: CSR bus between an initiator and generated register blocks
// master drives valid/address/write/write_data; the target returns ready/status/read_data.
interface riscv_csrbus_if #(
    parameter int XLEN = 64,
    parameter int ADDRESS_WIDTH = 15
) ();
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [XLEN-1:0]          write_data;
    logic                     ready;
    logic [1:0]               status;
    logic [XLEN-1:0]          read_data;
    modport master (output valid, address, write, write_data, input ready, status, read_data);
    modport slave (input valid, address, write, write_data, output ready, status, read_data);
endinterface

// File: rtl/riscv_csr_op_alu.sv
// riscv_csr_op_alu: Zicsr new-value computation and access decision
// Ports: op (funct3), old_value, operand, src_is_x0, rd_is_x0 in; new_value, do_read, do_write out.
module riscv_csr_op_alu
    import riscv_csrbus_initiator_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] old_value,
    input  logic [XLEN-1:0] operand,
    input  logic            src_is_x0,
    input  logic            rd_is_x0,
    output logic [XLEN-1:0] new_value,
    output logic            do_read,
    output logic            do_write
);
    logic is_rw, is_rs;
    always_comb begin
        is_rw = op == CSR_RW || op == CSR_RWI;
        is_rs = op == CSR_RS || op == CSR_RSI;
        new_value = is_rw ? operand : is_rs ? (old_value | operand) : (old_value & ~operand);
        do_write = is_rw || !src_is_x0;
        do_read = !(is_rw && rd_is_x0);
    end
endmodule

// File: rtl/riscv_csrbus_initiator.sv
// riscv_csrbus_initiator: executes one Zicsr request as CSR bus read/write accesses
// Ports: i_clk/i_rst; request i_req_* with o_req_ready and i_priv; response o_rsp_valid/
// i_rsp_ready/o_rsp_rdata/o_rsp_illegal; csrbus_if master side with registered outputs.
module riscv_csrbus_initiator
    import riscv_csrbus_initiator_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ADDRESS_WIDTH = 15,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_op,
    input  logic [11:0]     i_req_csr,
    input  logic [XLEN-1:0] i_req_operand,
    input  logic            i_req_src_is_x0,
    input  logic            i_req_rd_is_x0,
    input  logic [1:0]      i_priv,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_illegal,
    riscv_csrbus_if.master  csrbus_if
);
    localparam int SHIFT = $clog2(XLEN / 8);
    state_e state, state_d;
    logic [2:0] op_q;
    logic [XLEN-1:0] operand_q, new_value, write_data_d, rdata_d;
    logic [ADDRESS_WIDTH-1:0] address_d;
    logic [31:0] cnt, cnt_d;
    logic do_write_q, do_read, do_write, accept, illegal, timeout, bus_ok;
    logic valid_d, write_d, rsp_valid_d, illegal_d, req_ready_d;
    // In IDLE the ALU sees the live request with old value 0 (write-only path);
    // in READ it sees the captured request and the returned read data.
    riscv_csr_op_alu #(.XLEN(XLEN)) u_alu (
        .op        (state == IDLE ? i_req_op : op_q),
        .old_value (state == READ ? csrbus_if.read_data : '0),
        .operand   (state == IDLE ? i_req_operand : operand_q),
        .src_is_x0 (i_req_src_is_x0),
        .rd_is_x0  (i_req_rd_is_x0),
        .new_value (new_value),
        .do_read   (do_read),
        .do_write  (do_write)
    );
    assign accept = i_req_valid && o_req_ready;
    assign illegal = i_req_op[1:0] == 2'b00 || i_req_csr[9:8] > i_priv ||
                     (do_write && i_req_csr[11:10] == RO_FIELD);
    assign timeout = TIMEOUT_CYCLES != 0 && cnt + 32'd1 == 32'(TIMEOUT_CYCLES);
    assign bus_ok = csrbus_if.status == 2'b00;
    always_comb begin
        state_d = state;
        valid_d = csrbus_if.valid;
        write_d = csrbus_if.write;
        address_d = csrbus_if.address;
        write_data_d = csrbus_if.write_data;
        rdata_d = o_rsp_rdata;
        illegal_d = o_rsp_illegal;
        rsp_valid_d = o_rsp_valid;
        cnt_d = cnt;
        case (state)
            IDLE: if (accept) begin
                address_d = ADDRESS_WIDTH'(i_req_csr) << SHIFT;
                rdata_d = '0;
                illegal_d = illegal;
                cnt_d = '0;
                state_d = illegal ? RESP : do_read ? READ : WRITE;
                rsp_valid_d = illegal;
                valid_d = !illegal;
                write_d = !illegal && !do_read;
                write_data_d = new_value;
            end
            READ, WRITE: if (csrbus_if.ready) begin
                if (state == READ && bus_ok && do_write_q) begin
                    state_d = WRITE;
                    write_d = 1'b1;
                    write_data_d = new_value;
                    rdata_d = csrbus_if.read_data;
                    cnt_d = '0;
                end else begin
                    state_d = RESP;
                    valid_d = 1'b0;
                    write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    illegal_d = !bus_ok;
                    rdata_d = !bus_ok ? '0 : state == READ ? csrbus_if.read_data : o_rsp_rdata;
                end
            end else if (timeout) begin
                state_d = RESP;
                valid_d = 1'b0;
                write_d = 1'b0;
                rsp_valid_d = 1'b1;
                illegal_d = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt + 32'd1;
            end
            RESP: if (i_rsp_ready) begin
                state_d = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = state_d == IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_illegal <= 1'b0;
            csrbus_if.valid <= 1'b0;
            csrbus_if.write <= 1'b0;
            csrbus_if.address <= '0;
            csrbus_if.write_data <= '0;
            cnt <= '0;
            op_q <= '0;
            operand_q <= '0;
            do_write_q <= 1'b0;
        end else begin
            state <= state_d;
            o_req_ready <= req_ready_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_rdata <= rdata_d;
            o_rsp_illegal <= illegal_d;
            csrbus_if.valid <= valid_d;
            csrbus_if.write <= write_d;
            csrbus_if.address <= address_d;
            csrbus_if.write_data <= write_data_d;
            cnt <= cnt_d;
            if (accept) begin
                op_q <= i_req_op;
                operand_q <= i_req_operand;
                do_write_q <= do_write;
            end
        end
    end
endmodule

// File: tb/tb_riscv_csrbus_initiator.sv
// tb_riscv_csrbus_initiator: directed bench with a transaction-level model and a per-cycle monitor
module tb_riscv_csrbus_initiator;
    import riscv_csrbus_initiator_pkg::*;
    localparam int TMO = 4;
    typedef struct {logic w; logic [14:0] a; logic [63:0] d;} acc_t;
    typedef struct {logic [63:0] rd; logic ill;} rsp_t;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready, src0 = 0, rd0 = 0, rsp_valid, rsp_ready = 0, rsp_illegal;
    logic [2:0] req_op = 0;
    logic [11:0] req_csr = 0;
    logic [63:0] req_operand = 0, rsp_rdata, slv_rdata = 0;
    logic [1:0] priv = 0, st_rd = 0, st_wr = 0;
    logic hang = 0;
    int stall_cfg = 0, stall_cnt = 0;
    int n_chk = 0, n_err = 0, n_acc = 0, n_mark = 0, last_lat = 0;
    logic [14:0] last_addr = 0;
    logic [63:0] last_wdata = 0, last_rdata = 0;
    logic last_ill = 0, chk_en = 0;
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    riscv_csrbus_if #(.XLEN(64), .ADDRESS_WIDTH(15)) bus ();
    assign bus.ready = bus.valid && !hang && stall_cnt == 0;
    assign bus.status = bus.write ? st_wr : st_rd;
    assign bus.read_data = slv_rdata;
    riscv_csrbus_initiator #(.XLEN(64), .ADDRESS_WIDTH(15), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_csr(req_csr), .i_req_operand(req_operand),
        .i_req_src_is_x0(src0), .i_req_rd_is_x0(rd0), .i_priv(priv),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_illegal(rsp_illegal), .csrbus_if(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) stall_cnt <= (bus.valid && !bus.ready) ? stall_cnt - 1 : stall_cfg;
    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction
    // Per-cycle monitor: handshakes against the model queues, hold rules, timeout drop, ready.
    initial begin
        logic prev_rst, prev_v, prev_r, prev_w, prev_rv, prev_rr, prev_ill, busy, exp_rdy;
        logic [14:0] prev_a;
        logic [63:0] prev_d, prev_rd;
        int run;
        acc_t a;
        rsp_t r;
        prev_rst = 1; prev_v = 0; prev_r = 0; prev_w = 0; prev_rv = 0; prev_rr = 0; prev_ill = 0;
        busy = 0; exp_rdy = 0; prev_a = 0; prev_d = 0; prev_rd = 0; run = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (prev_rst) begin
                    chk("reset_ctrl", {47'd0, bus.valid, bus.write, rsp_valid, rsp_illegal, req_ready, bus.address[11:0]} | {49'd0, bus.address}, 64'd0);
                    chk("reset_data", bus.write_data | rsp_rdata, 64'd0);
                end else begin
                    if (prev_v && !prev_r) begin
                        if (run == TMO) chk("timeout_drop", {63'd0, bus.valid}, 64'd0);
                        else begin
                            chk("bus_hold", {47'd0, bus.valid, bus.write, bus.address}, {47'd0, 1'b1, prev_w, prev_a});
                            chk("bus_hold_wdata", bus.write_data, prev_d);
                        end
                    end
                    if (prev_rv && !prev_rr) begin
                        chk("rsp_hold", {62'd0, rsp_valid, rsp_illegal}, {62'd0, 1'b1, prev_ill});
                        chk("rsp_hold_rdata", rsp_rdata, prev_rd);
                    end
                end
                chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
                if (bus.valid && bus.ready) begin
                    n_acc++;
                    last_addr = bus.address;
                    if (bus.write) last_wdata = bus.write_data;
                    if (exp_acc.size() == 0) chk("unexpected_access", {48'd0, bus.write, bus.address}, 64'hFFFF_FFFF);
                    else begin
                        a = exp_acc.pop_front();
                        chk("acc_kind_addr", {48'd0, bus.write, bus.address}, {48'd0, a.w, a.a});
                        if (a.w) chk("acc_wdata", bus.write_data, a.d);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    last_rdata = rsp_rdata;
                    last_ill = rsp_illegal;
                    chk("acc_pending", 64'(exp_acc.size()), 64'd0);
                    exp_acc.delete();
                    if (exp_rsp.size() == 0) chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                    else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.rd);
                        chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, r.ill});
                    end
                end
                busy = rst ? 1'b0 : (req_valid && req_ready) ? 1'b1 : (rsp_valid && rsp_ready) ? 1'b0 : busy;
                exp_rdy = !rst && !busy;
                run = (!rst && bus.valid && !bus.ready) ? run + 1 : 0;
                prev_rst = rst; prev_v = bus.valid; prev_r = bus.ready; prev_w = bus.write;
                prev_a = bus.address; prev_d = bus.write_data;
                prev_rv = rsp_valid; prev_rr = rsp_ready; prev_ill = rsp_illegal; prev_rd = rsp_rdata;
            end
        end
    end
    task automatic send(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] opd,
                        input logic s0, input logic r0, input logic [1:0] pv);
        int w;
        w = 0;
        req_op = op; req_csr = csr; req_operand = opd; src0 = s0; rd0 = r0; priv = pv;
        req_valid = 1;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask
    // Model: derive the expected access list, response and latency from the instruction rules.
    task automatic txn(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] opd,
                       input logic s0, input logic r0, input logic [1:0] pv, input logic [63:0] rdv,
                       input logic [1:0] srd, input logic [1:0] swr, input int stall, input logic hng,
                       input int rstall);
        logic rw, dw, dr, legal, ill;
        logic [63:0] old;
        int exp_lat, lat;
        acc_t a;
        rsp_t r;
        rw = op == 3'b001 || op == 3'b101;
        dw = rw || !s0;
        dr = !(rw && r0);
        legal = op != 3'b000 && op != 3'b100 && csr[9:8] <= pv && !(dw && csr[11:10] == 2'b11);
        ill = !legal;
        old = 0;
        exp_lat = 1;
        a.a = 15'(csr * 8);
        if (legal && dr) begin
            if (hng) begin ill = 1; exp_lat += TMO; end
            else begin
                a.w = 0; a.d = 0;
                exp_acc.push_back(a);
                exp_lat += 1 + stall;
                if (srd != 0) ill = 1; else old = rdv;
            end
        end
        if (!ill && dw) begin
            if (hng) begin ill = 1; exp_lat += TMO; end
            else begin
                a.w = 1;
                a.d = op[1:0] == 2'b01 ? opd : op[1:0] == 2'b10 ? (old | opd) : (old & ~opd);
                exp_acc.push_back(a);
                exp_lat += 1 + stall;
                if (swr != 0) ill = 1;
            end
        end
        r.rd = ill ? 64'd0 : old;
        r.ill = ill;
        exp_rsp.push_back(r);
        slv_rdata = rdv; st_rd = srd; st_wr = swr; stall_cfg = stall; hang = hng;
        send(op, csr, opd, s0, r0, pv);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        last_lat = lat;
        chk("latency", 64'(lat), 64'(exp_lat));
        for (int k = 0; k < rstall; k++) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        hang = 0;
        stall_cfg = 0;
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
        n_mark = n_acc;
        txn(3'b001, 12'h305, 64'h8000_0000_0000_0101, 0, 0, PRIV_M, 64'h0, 0, 0, 0, 0, 0);
        chk("t1_addr", {49'd0, last_addr}, 64'h1828);
        chk("t1_wdata", last_wdata, 64'h8000_0000_0000_0101);
        chk("t1_nacc", 64'(n_acc - n_mark), 64'd2);
        chk("t1_lat", 64'(last_lat), 64'd3);
        chk("t1_rsp", {last_rdata[62:0], last_ill}, 64'd0);
        n_mark = n_acc;
        txn(3'b010, 12'h305, 64'h0, 1, 0, PRIV_M, 64'h1234, 0, 0, 0, 0, 0);
        chk("t2_nacc", 64'(n_acc - n_mark), 64'd1);
        chk("t2_rdata", last_rdata, 64'h1234);
        chk("t2_lat", 64'(last_lat), 64'd2);
        txn(3'b011, 12'h305, 64'hF, 0, 0, PRIV_M, 64'hFF, 0, 0, 0, 0, 0);
        chk("t3_wdata", last_wdata, 64'hF0);
        chk("t3_rdata", last_rdata, 64'hFF);
        n_mark = n_acc;
        txn(3'b101, 12'h340, 64'h5, 0, 1, PRIV_M, 64'hDEAD, 0, 0, 0, 0, 0);
        chk("t3b_nacc", 64'(n_acc - n_mark), 64'd1);
        chk("t3b_addr", {49'd0, last_addr}, 64'h1A00);
        chk("t3b_rdata", last_rdata, 64'd0);
        n_mark = n_acc;
        txn(3'b001, 12'hC00, 64'h1, 0, 0, PRIV_M, 64'h0, 0, 0, 0, 0, 0);
        chk("t4_ill", {63'd0, last_ill}, 64'd1);
        chk("t4_nacc", 64'(n_acc - n_mark), 64'd0);
        chk("t4_lat", 64'(last_lat), 64'd1);
        txn(3'b010, 12'h305, 64'h1, 0, 0, PRIV_U, 64'h0, 0, 0, 0, 0, 0);
        chk("t4b_ill", {63'd0, last_ill}, 64'd1);
        txn(3'b010, 12'hC00, 64'h0, 1, 0, PRIV_M, 64'h77, 0, 0, 0, 0, 0);
        chk("t4c_addr", {49'd0, last_addr}, 64'h6000);
        chk("t4c_rsp", {last_rdata[62:0], last_ill}, {63'h77, 1'b0});
        txn(3'b000, 12'h305, 64'h1, 0, 0, PRIV_M, 64'h0, 0, 0, 0, 0, 0);
        txn(3'b100, 12'h305, 64'h1, 0, 0, PRIV_M, 64'h0, 0, 0, 0, 0, 0);
        txn(3'b110, 12'h100, 64'h2, 0, 0, PRIV_S, 64'h1, 0, 0, 0, 0, 0);
        chk("rsi_wdata", last_wdata, 64'h3);
        txn(3'b110, 12'h305, 64'h2, 0, 0, PRIV_S, 64'h1, 0, 0, 0, 0, 0);
        txn(3'b111, 12'h340, 64'h0, 1, 0, PRIV_M, 64'hAB, 0, 0, 0, 0, 0);
        txn(3'b010, 12'h340, 64'h1, 0, 0, PRIV_M, 64'h10, 0, 0, 3, 0, 0);
        chk("t5_wdata", last_wdata, 64'h11);
        chk("t5_lat", 64'(last_lat), 64'd9);
        n_mark = n_acc;
        txn(3'b001, 12'h340, 64'h9, 0, 0, PRIV_M, 64'h5, 0, 0, 0, 1, 0);
        chk("t5b_lat", 64'(last_lat), 64'd5);
        chk("t5b_rsp", {last_rdata[62:0], last_ill}, 64'd1);
        chk("t5b_nacc", 64'(n_acc - n_mark), 64'd0);
        n_mark = n_acc;
        txn(3'b010, 12'h340, 64'h1, 0, 0, PRIV_M, 64'h5, 2'b01, 0, 0, 0, 0);
        chk("t5c_nacc", 64'(n_acc - n_mark), 64'd1);
        chk("t5c_ill", {63'd0, last_ill}, 64'd1);
        txn(3'b001, 12'h340, 64'h3, 0, 0, PRIV_M, 64'h5, 0, 2'b10, 1, 0, 0);
        chk("t5d_rsp", {last_rdata[62:0], last_ill}, 64'd1);
        txn(3'b010, 12'h341, 64'h0, 1, 0, PRIV_M, 64'hCAFE, 0, 0, 0, 0, 5);
        chk("t6_rdata", last_rdata, 64'hCAFE);
        stall_cfg = 5;
        send(3'b101, 12'h340, 64'h7, 0, 1, PRIV_M);
        chk("t6_in_write", {62'd0, bus.valid, bus.write}, 64'd3);
        rst = 1;
        @(posedge clk); #1;
        chk("t6_rst_idle", {62'd0, bus.valid, rsp_valid}, 64'd0);
        rst = 0;
        stall_cfg = 0;
        @(posedge clk); #1;
        chk("t6_ready_back", {63'd0, req_ready}, 64'd1);
        txn(3'b010, 12'h305, 64'h0, 1, 0, PRIV_M, 64'h42, 0, 0, 0, 0, 0);
        chk("t6_recover", last_rdata, 64'h42);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
